n2_exec_pipe: RTL and testbench

//  Parametrised integer execute stage for the NanoCore issue pipeline. Computes RV32I ALU ops,

---
 rtl/n2_exec_pipe.sv | 162 ++++++++++++++++
 tb/tb_n2_exec_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/n2_exec_pipe.sv
// NanoCore integer execute stage: RV32I ALU, branch/JALR resolution, ALU_LAT-deep result pipe.
// Optional front-end prediction check and BTB update under `N2_EXEC_BP_EN.
module n2_exec_pipe #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1,
  parameter int UID_W   = 8,
  parameter int RIDX_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              in_v_i,
  output logic              in_rdy_o,
  input  logic [UID_W-1:0]  uid_i,
  input  logic [4:0]        op_i,
  input  logic [RIDX_W-1:0] rd_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
`ifdef N2_EXEC_BP_EN
  input  logic              pred_jump_i,
  input  logic [XLEN-1:0]   pred_tgt_i,
  output logic              btb_upd_v_o,
  output logic              btb_upd_valid_o,
  output logic              btb_upd_jalr_o,
  output logic [XLEN-1:0]   btb_upd_pc_o,
  output logic [XLEN-1:0]   btb_upd_tgt_o,
`endif
  output logic              out_v_o,
  input  logic              out_rdy_i,
  output logic [UID_W-1:0]  uid_o,
  output logic [RIDX_W-1:0] rd_o,
  output logic              rf_we_o,
  output logic [XLEN-1:0]   rst_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  localparam int SH_W = $clog2(XLEN);

  typedef struct packed {
    logic              vld;
    logic [UID_W-1:0]  uid;
    logic [RIDX_W-1:0] rd;
    logic              we;
    logic [XLEN-1:0]   res;
    logic              redir;
    logic [XLEN-1:0]   rpc;
`ifdef N2_EXEC_BP_EN
    logic              bvalid;
    logic              bjalr;
    logic [XLEN-1:0]   bpc;
    logic [XLEN-1:0]   btgt;
`endif
  } slot_t;

  logic signed [XLEN-1:0] op1_s, op2_s;
  logic [SH_W-1:0]        shamt;
  logic [XLEN-1:0]        pc_seq, br_tgt, jalr_sum, jalr_tgt;
  logic                   rd_nz, adv;
  logic                   is_br, is_jalr, taken;
  slot_t                  slot_p0;
  slot_t                  slot_p1 [ALU_LAT];
  slot_t                  out_slot;

  assign op1_s    = op1_i;
  assign op2_s    = op2_i;
  assign shamt    = op2_i[SH_W-1:0];
  assign pc_seq   = pc_i + XLEN'(4);
  assign br_tgt   = pc_i + imm_i;
  assign jalr_sum = op1_i + imm_i;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign rd_nz    = (rd_i != '0);

  assign out_slot = slot_p1[ALU_LAT-1];
  assign adv      = !out_slot.vld | out_rdy_i;
  assign in_rdy_o = adv;

  // p0: compute result and redirect payload for the op being offered
  always_comb begin
    slot_p0 = '0;
    is_br   = 1'b0;
    is_jalr = 1'b0;
    taken   = 1'b0;
    slot_p0.vld = in_v_i & adv & !flush_i;
    slot_p0.uid = uid_i;
    slot_p0.rd  = rd_i;
    case (op_i)
      5'd0:  begin slot_p0.res = op1_i + op2_i;        slot_p0.we = rd_nz; end
      5'd1:  begin slot_p0.res = op1_i - op2_i;        slot_p0.we = rd_nz; end
      5'd2:  begin slot_p0.res = op1_i ^ op2_i;        slot_p0.we = rd_nz; end
      5'd3:  begin slot_p0.res = op1_i | op2_i;        slot_p0.we = rd_nz; end
      5'd4:  begin slot_p0.res = op1_i & op2_i;        slot_p0.we = rd_nz; end
      5'd5:  begin slot_p0.res = op1_i << shamt;       slot_p0.we = rd_nz; end
      5'd6:  begin slot_p0.res = op1_i >> shamt;       slot_p0.we = rd_nz; end
      5'd7:  begin slot_p0.res = op1_s >>> shamt;      slot_p0.we = rd_nz; end
      5'd8:  begin slot_p0.res = XLEN'(op1_s < op2_s); slot_p0.we = rd_nz; end
      5'd9:  begin slot_p0.res = XLEN'(op1_i < op2_i); slot_p0.we = rd_nz; end
      5'd10: begin is_br = 1'b1; taken = (op1_i == op2_i); end
      5'd11: begin is_br = 1'b1; taken = (op1_i != op2_i); end
      5'd12: begin is_br = 1'b1; taken = (op1_s <  op2_s); end
      5'd13: begin is_br = 1'b1; taken = (op1_s >= op2_s); end
      5'd14: begin is_br = 1'b1; taken = (op1_i <  op2_i); end
      5'd15: begin is_br = 1'b1; taken = (op1_i >= op2_i); end
      5'd16: begin is_jalr = 1'b1; taken = 1'b1; slot_p0.res = pc_seq; slot_p0.we = rd_nz; end
      default: ;
    endcase
    if (is_br) begin
      slot_p0.rpc = taken ? br_tgt : pc_seq;
`ifdef N2_EXEC_BP_EN
      slot_p0.redir = (taken ^ pred_jump_i) | (taken & pred_jump_i & (pred_tgt_i != br_tgt));
`else
      slot_p0.redir = taken;
`endif
    end
    if (is_jalr) begin
      slot_p0.rpc = jalr_tgt;
`ifdef N2_EXEC_BP_EN
      slot_p0.redir = !pred_jump_i | (pred_tgt_i != jalr_tgt);
`else
      slot_p0.redir = 1'b1;
`endif
    end
`ifdef N2_EXEC_BP_EN
    slot_p0.bvalid = taken;
    slot_p0.bjalr  = is_jalr;
    slot_p0.bpc    = pc_i;
    slot_p0.btgt   = taken ? (is_jalr ? jalr_tgt : br_tgt) : '0;
`endif
    // empty slots carry all-zero payload so idle outputs read as 0
    if (!slot_p0.vld) slot_p0 = '0;
  end

  // p1..pN: lock-step slot shift; any stall freezes the whole pipe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ALU_LAT; i++) slot_p1[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ALU_LAT; i++) slot_p1[i] <= '0;
    end else if (adv) begin
      slot_p1[0] <= slot_p0;
      for (int i = 1; i < ALU_LAT; i++) slot_p1[i] <= slot_p1[i-1];
    end
  end

  assign out_v_o       = out_slot.vld;
  assign uid_o         = out_slot.uid;
  assign rd_o          = out_slot.rd;
  assign rf_we_o       = out_slot.we;
  assign rst_o         = out_slot.res;
  assign redirect_o    = out_slot.redir;
  assign redirect_pc_o = out_slot.rpc;
`ifdef N2_EXEC_BP_EN
  assign btb_upd_v_o     = out_slot.vld & out_rdy_i & out_slot.redir;
  assign btb_upd_valid_o = out_slot.bvalid;
  assign btb_upd_jalr_o  = out_slot.bjalr;
  assign btb_upd_pc_o    = out_slot.bpc;
  assign btb_upd_tgt_o   = out_slot.btgt;
`endif

endmodule

// File: tb/tb_n2_exec_pipe.sv
// Directed self-checking bench for n2_exec_pipe at ALU_LAT=2.
module tb_n2_exec_pipe;
  localparam int XLEN = 32;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic resetn, flush_i, in_v_i, in_rdy_o, out_v_o, out_rdy_i;
  logic [7:0]  uid_i, uid_o;
  logic [4:0]  op_i, rd_i, rd_o;
  logic [31:0] op1_i, op2_i, pc_i, imm_i, rst_o, redirect_pc_o;
  logic rf_we_o, redirect_o;
`ifdef N2_EXEC_BP_EN
  logic pred_jump_i, btb_upd_v_o, btb_upd_valid_o, btb_upd_jalr_o;
  logic [31:0] pred_tgt_i, btb_upd_pc_o, btb_upd_tgt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  n2_exec_pipe #(.XLEN(XLEN), .ALU_LAT(LAT), .UID_W(8), .RIDX_W(5)) dut (
    .clk(clk), .resetn(resetn), .flush_i(flush_i), .in_v_i(in_v_i), .in_rdy_o(in_rdy_o),
    .uid_i(uid_i), .op_i(op_i), .rd_i(rd_i), .op1_i(op1_i), .op2_i(op2_i), .pc_i(pc_i), .imm_i(imm_i),
`ifdef N2_EXEC_BP_EN
    .pred_jump_i(pred_jump_i), .pred_tgt_i(pred_tgt_i), .btb_upd_v_o(btb_upd_v_o),
    .btb_upd_valid_o(btb_upd_valid_o), .btb_upd_jalr_o(btb_upd_jalr_o),
    .btb_upd_pc_o(btb_upd_pc_o), .btb_upd_tgt_o(btb_upd_tgt_o),
`endif
    .out_v_o(out_v_o), .out_rdy_i(out_rdy_i), .uid_o(uid_o), .rd_o(rd_o), .rf_we_o(rf_we_o),
    .rst_o(rst_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [7:0] uid,
                       input logic [31:0] pc, input logic [31:0] imm);
    op_i = op; op1_i = a; op2_i = b; rd_i = rd; uid_i = uid; pc_i = pc; imm_i = imm; in_v_i = 1'b1;
  endtask

  // Offer one op at a negedge, let it be accepted, return at the negedge its result is visible.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [7:0] uid,
                      input logic [31:0] pc, input logic [31:0] imm);
    drive(op, a, b, rd, uid, pc, imm);
    @(posedge clk);
    @(negedge clk);
    in_v_i = 1'b0;
    repeat (LAT-1) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; flush_i = 1'b0; in_v_i = 1'b0; out_rdy_i = 1'b1;
    drive(5'd0, 32'h0, 32'h0, 5'd0, 8'h0, 32'h0, 32'h0); in_v_i = 1'b0;
`ifdef N2_EXEC_BP_EN
    pred_jump_i = 1'b0; pred_tgt_i = 32'h0;
`endif
    repeat (3) @(negedge clk);
    total++; if (out_v_o !== 1'b0) $display("FAIL reset_out_v got %b exp 0", out_v_o); else passed++;
    total++; if (rst_o !== 32'h0) $display("FAIL reset_rst got %h exp 0", rst_o); else passed++;
    total++; if (rf_we_o !== 1'b0 || redirect_o !== 1'b0) $display("FAIL reset_ctl got we=%b redir=%b exp 0/0", rf_we_o, redirect_o); else passed++;
    resetn = 1'b1;
    @(negedge clk);
    total++; if (in_rdy_o !== 1'b1) $display("FAIL reset_in_rdy got %b exp 1", in_rdy_o); else passed++;
  endtask

  task automatic test_add_latency;
    drive(5'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 8'h01, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    in_v_i = 1'b0;
    total++; if (out_v_o !== 1'b0) $display("FAIL add_early got out_v=%b exp 0", out_v_o); else passed++;
    @(negedge clk);
    total++; if (out_v_o !== 1'b1) $display("FAIL add_v got %b exp 1", out_v_o); else passed++;
    total++; if (rst_o !== 32'h0) $display("FAIL add_rst got %h exp 00000000", rst_o); else passed++;
    total++; if (rf_we_o !== 1'b1 || rd_o !== 5'd3 || uid_o !== 8'h01) $display("FAIL add_meta got we=%b rd=%0d uid=%h exp 1/3/01", rf_we_o, rd_o, uid_o); else passed++;
    @(negedge clk);
    total++; if (out_v_o !== 1'b0) $display("FAIL add_drain got %b exp 0", out_v_o); else passed++;
  endtask

  task automatic test_alu_ops;
    send(5'd7, 32'h8000_0000, 32'h24, 5'd5, 8'h02, 32'h0, 32'h0);
    total++; if (rst_o !== 32'hF800_0000 || rf_we_o !== 1'b1) $display("FAIL sra got %h we=%b exp f8000000 we=1", rst_o, rf_we_o); else passed++;
    send(5'd9, 32'h1, 32'hFFFF_FFFF, 5'd6, 8'h03, 32'h0, 32'h0);
    total++; if (rst_o !== 32'h1) $display("FAIL sltu got %h exp 1", rst_o); else passed++;
    send(5'd8, 32'h1, 32'hFFFF_FFFF, 5'd6, 8'h04, 32'h0, 32'h0);
    total++; if (rst_o !== 32'h0) $display("FAIL slt got %h exp 0", rst_o); else passed++;
    send(5'd0, 32'h5, 32'h6, 5'd0, 8'h05, 32'h0, 32'h0);
    total++; if (out_v_o !== 1'b1 || rf_we_o !== 1'b0 || rst_o !== 32'hB) $display("FAIL add_rd0 got v=%b we=%b rst=%h exp 1/0/b", out_v_o, rf_we_o, rst_o); else passed++;
    send(5'd5, 32'h0000_0003, 32'h21, 5'd7, 8'h06, 32'h0, 32'h0);
    total++; if (rst_o !== 32'h6) $display("FAIL sll got %h exp 6", rst_o); else passed++;
    send(5'd6, 32'h8000_0000, 32'h1F, 5'd7, 8'h07, 32'h0, 32'h0);
    total++; if (rst_o !== 32'h1) $display("FAIL srl got %h exp 1", rst_o); else passed++;
    send(5'd20, 32'h1, 32'h2, 5'd7, 8'h08, 32'h0, 32'h0);
    total++; if (out_v_o !== 1'b1 || rf_we_o !== 1'b0 || redirect_o !== 1'b0) $display("FAIL reserved got v=%b we=%b redir=%b exp 1/0/0", out_v_o, rf_we_o, redirect_o); else passed++;
  endtask

  task automatic test_back_to_back;
    drive(5'd0, 32'h1, 32'h2, 5'd1, 8'h10, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    drive(5'd1, 32'hA, 32'h3, 5'd2, 8'h11, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    drive(5'd2, 32'hF0, 32'hFF, 5'd3, 8'h12, 32'h0, 32'h0);
    out_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_v_o !== 1'b1 || uid_o !== 8'h10 || rst_o !== 32'h3 || in_rdy_o !== 1'b0)
        $display("FAIL stall_hold%0d got v=%b uid=%h rst=%h rdy=%b exp 1/10/3/0", i, out_v_o, uid_o, rst_o, in_rdy_o);
      else passed++;
    end
    out_rdy_i = 1'b1;
    @(posedge clk); @(negedge clk);
    in_v_i = 1'b0;
    total++; if (out_v_o !== 1'b1 || uid_o !== 8'h11 || rst_o !== 32'h7) $display("FAIL b2b_second got v=%b uid=%h rst=%h exp 1/11/7", out_v_o, uid_o, rst_o); else passed++;
    @(negedge clk);
    total++; if (out_v_o !== 1'b1 || uid_o !== 8'h12 || rst_o !== 32'h0F) $display("FAIL b2b_third got v=%b uid=%h rst=%h exp 1/12/f", out_v_o, uid_o, rst_o); else passed++;
    @(negedge clk);
    total++; if (out_v_o !== 1'b0) $display("FAIL b2b_empty got %b exp 0", out_v_o); else passed++;
  endtask

  task automatic test_flush;
    out_rdy_i = 1'b0;
    drive(5'd0, 32'h1, 32'h1, 5'd1, 8'h20, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    drive(5'd0, 32'h2, 32'h2, 5'd1, 8'h21, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    drive(5'd0, 32'h3, 32'h3, 5'd1, 8'h22, 32'h0, 32'h0);
    flush_i = 1'b1;
    @(posedge clk); @(negedge clk);
    flush_i = 1'b0; in_v_i = 1'b0; out_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_v_o !== 1'b0) $display("FAIL flush_empty%0d got out_v=%b uid=%h exp 0", i, out_v_o, uid_o); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_branch;
    send(5'd10, 32'h5, 32'h5, 5'd4, 8'h30, 32'h100, 32'h20);
    total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h120 || rf_we_o !== 1'b0) $display("FAIL beq got redir=%b pc=%h we=%b exp 1/120/0", redirect_o, redirect_pc_o, rf_we_o); else passed++;
`ifdef N2_EXEC_BP_EN
    total++; if (btb_upd_v_o !== 1'b1 || btb_upd_valid_o !== 1'b1 || btb_upd_tgt_o !== 32'h120) $display("FAIL beq_btb got v=%b valid=%b tgt=%h exp 1/1/120", btb_upd_v_o, btb_upd_valid_o, btb_upd_tgt_o); else passed++;
`endif
    send(5'd11, 32'h5, 32'h5, 5'd4, 8'h31, 32'h100, 32'h20);
    total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h104) $display("FAIL bne_nt got redir=%b pc=%h exp 0/104", redirect_o, redirect_pc_o); else passed++;
    send(5'd12, 32'hFFFF_FFFF, 32'h1, 5'd0, 8'h32, 32'h200, 32'hFFFF_FFF0);
    total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h1F0) $display("FAIL blt got redir=%b pc=%h exp 1/1f0", redirect_o, redirect_pc_o); else passed++;
    send(5'd14, 32'hFFFF_FFFF, 32'h1, 5'd0, 8'h33, 32'h200, 32'h40);
    total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h204) $display("FAIL bltu_nt got redir=%b pc=%h exp 0/204", redirect_o, redirect_pc_o); else passed++;
  endtask

  task automatic test_jalr;
`ifdef N2_EXEC_BP_EN
    pred_jump_i = 1'b1; pred_tgt_i = 32'h2000;
`endif
    send(5'd16, 32'h2001, 32'h0, 5'd1, 8'h40, 32'h400, 32'h0);
    total++; if (rst_o !== 32'h404 || rf_we_o !== 1'b1 || redirect_pc_o !== 32'h2000) $display("FAIL jalr got rst=%h we=%b pc=%h exp 404/1/2000", rst_o, rf_we_o, redirect_pc_o); else passed++;
`ifdef N2_EXEC_BP_EN
    total++; if (redirect_o !== 1'b0) $display("FAIL jalr_redir got %b exp 0", redirect_o); else passed++;
    pred_jump_i = 1'b0; pred_tgt_i = 32'h0;
`else
    total++; if (redirect_o !== 1'b1) $display("FAIL jalr_redir got %b exp 1", redirect_o); else passed++;
`endif
  endtask

  task automatic test_reset_mid;
    drive(5'd0, 32'h7, 32'h7, 5'd2, 8'h50, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    in_v_i = 1'b0;
    resetn = 1'b0;
    #1;
    total++; if (out_v_o !== 1'b0) $display("FAIL rstmid_now got %b exp 0", out_v_o); else passed++;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (out_v_o !== 1'b0) $display("FAIL rstmid_after%0d got %b exp 0", i, out_v_o); else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_add_latency;
    test_alu_ops;
    test_back_to_back;
    test_flush;
    test_branch;
    test_jalr;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
